// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage. Owns the PC, looks up a direct-mapped instruction
//   cache (one 32-bit word per line) and, on a miss, fetches a single word
//   from the memory controller. Presents the (pc, instruction) pair that the
//   IF/ID register latches; instruction 32'h0 is a bubble.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | looking up pc each unstalled cycle; hits stream one per cycle
//   FETCH | miss outstanding; mem_req_out held until mem_done_in
//
// Ports
//   clk_in, rst_in          clock, async active-low reset
//   rdy_in                  global enable; 0 freezes all state
//   stall_in[5:0]           bit 0 holds PC and fetch outputs
//   branch_or_not_in        taken branch/jump from EX this cycle
//   branch_target_in        redirect PC
//   mem_req_out             level request to memory controller
//   mem_addr_out            word address of the request
//   mem_done_in             1-cycle pulse, mem_data_in valid
//   mem_data_in             fetched instruction word
//   if_stall_req_out        miss outstanding, to stall controller
//   pc_out, instru_out      to IF/ID
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [5:0]  stall_in,
    input  logic        branch_or_not_in,
    input  logic [31:0] branch_target_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in,
    output logic        if_stall_req_out,
    output logic [31:0] pc_out,
    output logic [31:0] instru_out
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instru_q, instru_d;
    logic        req_q, req_d;
    logic [29:0] addr_q, addr_d;          // word address, byte offset is always 0
    logic        stall_req_q, stall_req_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [ICACHE_IDX_W-1:0] rd_idx, fill_idx;
    logic [TAG_W-1:0]        rd_tag, fill_tag;
    logic                    hit;
    logic                    fill_en;
    logic                    hold;
    logic                    unused_stall;

    assign unused_stall = ^stall_in[5:1];
    assign hold         = stall_in[0];

    assign rd_idx   = pc_q[ICACHE_IDX_W+1:2];
    assign rd_tag   = pc_q[31:ICACHE_IDX_W+2];
    assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    // The fill uses the latched request address, so a done pulse that lands
    // together with a branch still fills the line it belongs to.
    assign fill_idx = addr_q[ICACHE_IDX_W-1:0];
    assign fill_tag = addr_q[29:ICACHE_IDX_W];
    assign fill_en  = rdy_in && (state_q == FETCH) && mem_done_in;

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (branch_or_not_in) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (!hold && !hit) state_d = FETCH;
                    FETCH:   if (mem_done_in)   state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // ---------------- outputs / datapath next values ----------------
    always_comb begin
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instru_d    = instru_q;
        req_d       = req_q;
        addr_d      = addr_q;
        stall_req_d = stall_req_q;
        if (rdy_in) begin
            if (branch_or_not_in) begin
                pc_d        = branch_target_in;
                pc_out_d    = 32'h0;
                instru_d    = 32'h0;
                req_d       = 1'b0;
                stall_req_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!hold) begin
                            if (hit) begin
                                pc_out_d = pc_q;
                                instru_d = data_q[rd_idx];
                                pc_d     = pc_q + 32'd4;
                            end else begin
                                req_d       = 1'b1;
                                addr_d      = pc_q[31:2];
                                stall_req_d = 1'b1;
                                pc_out_d    = 32'h0;
                                instru_d    = 32'h0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_done_in) begin
                            req_d       = 1'b0;
                            stall_req_d = 1'b0;
                            // When held, the word is only cached; the next
                            // unstalled IDLE cycle picks it up as a hit.
                            if (!hold) begin
                                pc_out_d = pc_q;
                                instru_d = mem_data_in;
                                pc_d     = pc_q + 32'd4;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_q        <= RESET_PC;
            pc_out_q    <= 32'h0;
            instru_q    <= 32'h0;
            req_q       <= 1'b0;
            addr_q      <= 30'h0;
            stall_req_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            instru_q    <= instru_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            stall_req_q <= stall_req_d;
        end
    end

    // ---------------- cache arrays ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data_in;
        end
    end

    assign mem_req_out      = req_q;
    assign mem_addr_out     = {addr_q, 2'b00};
    assign if_stall_req_out = stall_req_q;
    assign pc_out           = pc_out_q;
    assign instru_out       = instru_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: the driver pushes the expected memory requests and
// instruction deliveries into queues; a monitor pops them when the DUT raises
// a request or presents a new non-bubble instruction.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [5:0]  stall;
    logic        branch;
    logic [31:0] target;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        if_stall_req_out;
    logic [31:0] pc_out;
    logic [31:0] instru_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_req [$];
    logic [63:0] exp_del [$];
    int          del_cycles [$];
    bit          auto_mem = 0;
    bit          lat_chk  = 0;
    int          req_cyc  = 0;

    if_fetch #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .rdy_in           (rdy),
        .stall_in         (stall),
        .branch_or_not_in (branch),
        .branch_target_in (target),
        .mem_req_out      (mem_req_out),
        .mem_addr_out     (mem_addr_out),
        .mem_done_in      (mem_done),
        .mem_data_in      (mem_data),
        .if_stall_req_out (if_stall_req_out),
        .pc_out           (pc_out),
        .instru_out       (instru_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check_empty(input string name);
        chk({name, "_req_q"}, exp_req.size(), 0);
        chk({name, "_del_q"}, exp_del.size(), 0);
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((exp_req.size() != 0 || exp_del.size() != 0) && n < budget);
        checks++;
        if (exp_req.size() != 0 || exp_del.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp_req.size(), exp_del.size());
        end
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            step();
            n++;
        end while (!mem_req_out && n < 20);
        chk("req_timeout", {31'h0, mem_req_out}, 32'h1);
    endtask

    // Redirect to addr, expect a miss there and serve it one cycle after the request.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data);
        branch = 1; target = addr; mem_done = 0;
        exp_req.push_back(addr);
        step();
        branch = 0;
        wait_req();
        mem_done = 1; mem_data = data;
        exp_del.push_back({addr, data});
        step();
        mem_done = 0;
        check_empty("fetch_miss");
    endtask

    // Scoreboard monitor
    initial begin
        logic        prev_req;
        logic [63:0] prev_del;
        logic [31:0] e32;
        logic [63:0] e64;
        prev_req = 0;
        prev_del = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("stall_req_tracks_req", {31'h0, if_stall_req_out}, {31'h0, mem_req_out});
                if (mem_req_out && !prev_req) begin
                    req_cyc = cyc;
                    if (exp_req.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req actual=%h required=none", mem_addr_out);
                    end else begin
                        e32 = exp_req.pop_front();
                        chk("req_addr", mem_addr_out, e32);
                    end
                end
                if (instru_out != 32'h0 && {pc_out, instru_out} != prev_del) begin
                    del_cycles.push_back(cyc);
                    if (lat_chk) chk("miss_latency", cyc - req_cyc, 4);
                    if (exp_del.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_delivery actual=%h/%h required=none", pc_out, instru_out);
                    end else begin
                        e64 = exp_del.pop_front();
                        chk("del_pc", pc_out, e64[63:32]);
                        chk("del_instr", instru_out, e64[31:0]);
                    end
                end
            end
            prev_req = mem_req_out;
            prev_del = {pc_out, instru_out};
        end
    end

    // Automatic memory with 4-cycle latency, used for the cold-cache walk.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (auto_mem) begin
                mem_done = 0;
                if (!mem_req_out) cnt = 0;
                else begin
                    cnt++;
                    if (cnt == 4) begin
                        mem_done = 1;
                        mem_data = 32'h00000013;
                        cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 0; rdy = 1; stall = 6'h0; branch = 0; target = 32'h0;
        mem_done = 0; mem_data = 32'h0;
        step(); step();
        chk("rst_req", {31'h0, mem_req_out}, 32'h0);
        chk("rst_addr", mem_addr_out, 32'h0);
        chk("rst_stall_req", {31'h0, if_stall_req_out}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr", instru_out, 32'h0);

        // Cold cache: three misses at 0,4,8 served by 4-cycle memory.
        auto_mem = 1; lat_chk = 1;
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        exp_del.push_back({32'h0, 32'h13});
        exp_del.push_back({32'h4, 32'h13});
        exp_del.push_back({32'h8, 32'h13});
        rst_n = 1;
        wait_drained(200);

        // Loop back: three consecutive hits, no requests.
        auto_mem = 0; lat_chk = 0; mem_done = 0;
        branch = 1; target = 32'h0;
        exp_del.push_back({32'h0, 32'h13});
        exp_del.push_back({32'h4, 32'h13});
        exp_del.push_back({32'h8, 32'h13});
        del_cycles.delete();
        step();
        branch = 0;
        wait_drained(20);
        chk("hit_count", del_cycles.size(), 3);
        if (del_cycles.size() == 3) chk("hit_span", del_cycles[2] - del_cycles[0], 2);

        // Branch while FETCH on 0x20 cancels the miss.
        branch = 1; target = 32'h20;
        exp_req.push_back(32'h20);
        step();
        branch = 0;
        wait_req();
        branch = 1; target = 32'h100;
        exp_req.push_back(32'h100);
        step();
        chk("cancel_req", {31'h0, mem_req_out}, 32'h0);
        chk("cancel_instr", instru_out, 32'h0);
        chk("cancel_pc_out", pc_out, 32'h0);
        branch = 0;
        wait_req();
        mem_done = 1; mem_data = 32'hAAAA0013;
        exp_del.push_back({32'h100, 32'hAAAA0013});
        step();
        mem_done = 0;
        check_empty("redirect");

        // 0x20 must still miss.
        fetch_miss(32'h20, 32'h20200013);

        // Branch and done in the same cycle on 0x40.
        branch = 1; target = 32'h40;
        exp_req.push_back(32'h40);
        step();
        branch = 0;
        wait_req();
        mem_done = 1; mem_data = 32'h40400013; branch = 1; target = 32'h300;
        step();
        chk("brdone_instr", instru_out, 32'h0);
        chk("brdone_req", {31'h0, mem_req_out}, 32'h0);
        chk("brdone_pc_out", pc_out, 32'h0);
        mem_done = 0; branch = 1; target = 32'h40;
        exp_del.push_back({32'h40, 32'h40400013});
        step();
        branch = 0;
        step();
        check_empty("brdone_hit");

        // Stall when done arrives, then release.
        branch = 1; target = 32'h60;
        exp_req.push_back(32'h60);
        step();
        branch = 0;
        wait_req();
        mem_done = 1; mem_data = 32'h60600013; stall = 6'h01;
        step();
        mem_done = 0;
        chk("stalldone_instr", instru_out, 32'h0);
        chk("stalldone_pc_out", pc_out, 32'h0);
        chk("stalldone_req", {31'h0, mem_req_out}, 32'h0);
        step(); step();
        chk("stallhold_instr", instru_out, 32'h0);
        stall = 6'h0;
        exp_del.push_back({32'h60, 32'h60600013});
        step();
        check_empty("stall_release");

        // Aliasing: index 0 currently holds 0x100.
        fetch_miss(32'h0, 32'h00000013);
        fetch_miss(32'h100, 32'hAAAA0013);
        fetch_miss(32'h0, 32'h00000013);

        // rdy_in=0 for 3 cycles mid-FETCH: branch and done ignored.
        branch = 1; target = 32'h80;
        exp_req.push_back(32'h80);
        step();
        branch = 0;
        wait_req();
        rdy = 0; branch = 1; target = 32'h200; mem_done = 1; mem_data = 32'hDEAD0013;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_req", {31'h0, mem_req_out}, 32'h1);
            chk("frz_addr", mem_addr_out, 32'h80);
            chk("frz_instr", instru_out, 32'h0);
        end
        rdy = 1; branch = 0; mem_done = 0;
        step();
        chk("unfrz_req", {31'h0, mem_req_out}, 32'h1);
        mem_done = 1; mem_data = 32'h80800013;
        exp_del.push_back({32'h80, 32'h80800013});
        step();
        mem_done = 0;
        check_empty("freeze");

        // Reset mid-FETCH: request drops at once; cache contents are gone.
        branch = 1; target = 32'hC0;
        exp_req.push_back(32'hC0);
        step();
        branch = 0;
        wait_req();
        rst_n = 0;
        #1;
        chk("arst_req", {31'h0, mem_req_out}, 32'h0);
        chk("arst_stall_req", {31'h0, if_stall_req_out}, 32'h0);
        step(); step();
        exp_req.push_back(32'h0);
        exp_del.push_back({32'h0, 32'h13});
        rst_n = 1;
        wait_req();
        mem_done = 1; mem_data = 32'h13;
        step();
        mem_done = 0;
        check_empty("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
